// File: rtl/taylor_pkg.sv
// Shared definitions for the taylor_mc multi-cycle MIPS core:
// opcodes, funct codes, FSM states, instruction classes and the ALU.
package taylor_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BEQ, C_BNE, C_JUMP, C_HALT, C_ILLEGAL
  } iclass_t;

  // Shifts operate on the rt operand (b), matching MIPS sll/srl.
  function automatic logic [31:0] alu_eval(alu_op_t op, logic [31:0] a, logic [31:0] b,
                                           logic [4:0] shamt);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLL: return b << shamt;
      ALU_SRL: return b >> shamt;
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/taylor_regfile.sv
// Register file for taylor_mc: two asynchronous read ports, one synchronous
// write port, register 0 always reads as zero.
module taylor_regfile
  #(parameter int NREGS = 32)
  (input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddr_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata);

  logic [31:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/taylor_mc.sv
// Multi-cycle MIPS core top: FETCH/DECODE/EXEC/MEM/WB/HALT FSM sharing one ALU
// and one data-memory port. Define TAYLOR_PERF_EN to build cycle/retire counters.
module taylor_mc
  import taylor_pkg::*;
  #(parameter int ADDR_W = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int NREGS = 32)
  (input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ready,
   output logic              retire,
   output logic [ADDR_W-1:0] retire_pc,
   output logic              illegal,
   output logic              halted,
   output logic [31:0]       cyc_cnt,
   output logic [31:0]       ret_cnt);

  state_t state, next_state;
  logic [ADDR_W-1:0] pc, cur_pc, br_target, j_target;
  logic [31:0] ir, a_reg, b_reg, alu_out, mdr;
  logic [31:0] sext_imm, zext_imm, alu_b, alu_res, rs_data, rt_data;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  iclass_t iclass;
  alu_op_t alu_op;
  logic use_zext, take_branch, rf_we;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign sext_imm = {{16{ir[15]}}, ir[15:0]};
  assign zext_imm = {16'd0, ir[15:0]};

  // Instruction classification; anything not listed falls through as illegal.
  always_comb begin
    iclass   = C_ILLEGAL;
    alu_op   = ALU_ADD;
    use_zext = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass = C_ALU_R;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          default: iclass = C_ILLEGAL;
        endcase
      end
      OP_ADDI: iclass = C_ALU_I;
      OP_SLTI: begin iclass = C_ALU_I; alu_op = ALU_SLT; end
      OP_ANDI: begin iclass = C_ALU_I; alu_op = ALU_AND; use_zext = 1'b1; end
      OP_ORI:  begin iclass = C_ALU_I; alu_op = ALU_OR;  use_zext = 1'b1; end
      OP_LW:   iclass = C_LOAD;
      OP_SW:   iclass = C_STORE;
      OP_BEQ:  iclass = C_BEQ;
      OP_BNE:  iclass = C_BNE;
      OP_J:    iclass = C_JUMP;
      OP_HALT: iclass = C_HALT;
      default: iclass = C_ILLEGAL;
    endcase
  end

  assign alu_b       = (iclass == C_ALU_R) ? b_reg : (use_zext ? zext_imm : sext_imm);
  assign alu_res     = alu_eval(alu_op, a_reg, alu_b, shamt);
  assign take_branch = ((iclass == C_BEQ) && (a_reg == b_reg)) ||
                       ((iclass == C_BNE) && (a_reg != b_reg));
  // pc already points past the branch when EXEC runs.
  assign br_target   = pc + ADDR_W'({sext_imm[29:0], 2'b00});
  assign j_target    = ADDR_W'({4'(32'(pc) >> 28), ir[25:0], 2'b00});

  assign rf_we = (state == S_WB);

  taylor_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .we      (rf_we),
    .waddr   ((iclass == C_ALU_R) ? rd : rt),
    .wdata   ((iclass == C_LOAD) ? mdr : alu_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        case (iclass)
          C_ALU_R, C_ALU_I: next_state = S_WB;
          C_LOAD, C_STORE:  next_state = S_MEM;
          C_HALT:           next_state = S_HALT;
          default:          next_state = S_FETCH;
        endcase
      end
      S_MEM:    if (dmem_ready) next_state = (iclass == C_STORE) ? S_FETCH : S_WB;
      S_WB:     next_state = S_FETCH;
      default:  next_state = S_HALT;
    endcase
  end

  // Datapath registers and the registered retire/illegal pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      cur_pc    <= RESET_PC;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      retire    <= 1'b0;
      retire_pc <= '0;
      illegal   <= 1'b0;
    end else begin
      retire  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_FETCH: begin
          ir     <= imem_rdata;
          cur_pc <= pc;
          pc     <= pc + ADDR_W'(4);
        end
        S_DECODE: begin
          a_reg <= rs_data;
          b_reg <= rt_data;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (take_branch)         pc <= br_target;
          else if (iclass == C_JUMP) pc <= j_target;
          if (iclass inside {C_BEQ, C_BNE, C_JUMP, C_HALT, C_ILLEGAL}) begin
            retire    <= 1'b1;
            retire_pc <= cur_pc;
            illegal   <= (iclass == C_ILLEGAL);
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (iclass == C_STORE) begin
              retire    <= 1'b1;
              retire_pc <= cur_pc;
            end else begin
              mdr <= dmem_rdata;
            end
          end
        end
        S_WB: begin
          retire    <= 1'b1;
          retire_pc <= cur_pc;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = (state == S_MEM) && (iclass == C_STORE);
  assign dmem_addr  = {alu_out[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = b_reg;
  assign halted     = (state == S_HALT);

`ifdef TAYLOR_PERF_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      ret_q <= ret_q + 32'(retire);
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_taylor_mc.sv
// Self-checking bench for taylor_mc: ISA-level reference model, stalling data
// memory with random wait states, directed and randomized programs.
module tb_taylor_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic        retire, illegal, halted;
  logic [11:0] retire_pc;
  logic [31:0] cyc_cnt, ret_cnt;

  taylor_mc #(.ADDR_W(12), .RESET_PC(12'h000), .NREGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .retire     (retire),
    .retire_pc  (retire_pc),
    .illegal    (illegal),
    .halted     (halted),
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] imem   [1024];
  logic [31:0] dmem   [1024];
  logic [31:0] m_mem  [1024];
  logic [31:0] m_regs [32];
  logic [11:0] m_pc;
  logic [31:0] prog [$];
  logic [11:0] ret_log [$];
  int          req_log [$];
  int          ill_cnt;
  int          force_wait = -1;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] HALT_W = {6'h3F, 26'd0};
  localparam logic [31:0] NOP_W  = 32'd0;

  assign imem_rdata = imem[imem_addr[11:2]];

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int target);
    return {6'h02, 26'(target)};
  endfunction

  task automatic load_prog();
    foreach (imem[i]) imem[i] = HALT_W;
    foreach (prog[i]) imem[i] = prog[i];
  endtask

  task automatic clear_mem(input bit randomize_data);
    foreach (dmem[i]) begin
      dmem[i]  = randomize_data ? $urandom : 32'd0;
      m_mem[i] = dmem[i];
    end
  endtask

  // Architectural effect of one instruction, straight from the ISA definition.
  task automatic model_step(output logic [11:0] rpc, output bit ill, output bit hlt,
                            output int lat, output bit st, output logic [31:0] sa,
                            output logic [31:0] sd);
    logic [31:0] w, va, vb, sx, zx, ea;
    int op, fn, rs, rt, rd, sh;
    w  = imem[m_pc[11:2]];
    op = int'(w[31:26]); fn = int'(w[5:0]);
    rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]); sh = int'(w[10:6]);
    va = m_regs[rs]; vb = m_regs[rt];
    sx = {{16{w[15]}}, w[15:0]}; zx = {16'd0, w[15:0]};
    rpc = m_pc; ill = 0; hlt = 0; lat = 3; st = 0; sa = '0; sd = '0;
    m_pc = m_pc + 12'd4;
    case (op)
      'h00: begin
        lat = 4;
        case (fn)
          'h20: if (rd != 0) m_regs[rd] = va + vb;
          'h22: if (rd != 0) m_regs[rd] = va - vb;
          'h24: if (rd != 0) m_regs[rd] = va & vb;
          'h25: if (rd != 0) m_regs[rd] = va | vb;
          'h2A: if (rd != 0) m_regs[rd] = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          'h00: if (rd != 0) m_regs[rd] = vb << sh;
          'h02: if (rd != 0) m_regs[rd] = vb >> sh;
          default: begin ill = 1; lat = 3; end
        endcase
      end
      'h08: begin lat = 4; if (rt != 0) m_regs[rt] = va + sx; end
      'h0A: begin lat = 4; if (rt != 0) m_regs[rt] = ($signed(va) < $signed(sx)) ? 32'd1 : 32'd0; end
      'h0C: begin lat = 4; if (rt != 0) m_regs[rt] = va & zx; end
      'h0D: begin lat = 4; if (rt != 0) m_regs[rt] = va | zx; end
      'h23: begin
        lat = 5; ea = (va + sx) & 32'hFFC;
        if (rt != 0) m_regs[rt] = m_mem[ea[11:2]];
      end
      'h2B: begin
        lat = 4; ea = (va + sx) & 32'hFFC;
        m_mem[ea[11:2]] = vb; st = 1; sa = ea; sd = vb;
      end
      'h04: if (va == vb) m_pc = m_pc + 12'(sx * 4);
      'h05: if (va != vb) m_pc = m_pc + 12'(sx * 4);
      'h02: m_pc = 12'(w[25:0] * 4);
      'h3F: hlt = 1;
      default: ill = 1;
    endcase
  endtask

  // Resets the core, then runs it against the model until halt or max_ret retires.
  task automatic run_prog(input int max_ret, input int budget);
    int cyc, last, nret, waits, wait_left, req_len, e_lat;
    bit done, st_seen, e_ill, e_hlt, e_st;
    logic [31:0] st_addr, st_data, e_sa, e_sd;
    logic [11:0] e_pc;
    rst = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    m_pc = 12'h000;
    foreach (m_regs[i]) m_regs[i] = '0;
    ret_log.delete(); req_log.delete(); ill_cnt = 0;
    cyc = 0; last = 0; nret = 0; waits = 0; wait_left = -1; req_len = 0;
    done = 0; st_seen = 0; st_addr = '0; st_data = '0;
    rst = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > budget) begin
        checks++; errors++;
        $display("[TB] FAIL budget: %0d retires after %0d cycles, required completion", nret, budget);
        break;
      end
      if (retire) begin
        model_step(e_pc, e_ill, e_hlt, e_lat, e_st, e_sa, e_sd);
        nret++;
        ret_log.push_back(retire_pc);
        if (illegal) ill_cnt++;
        checks++;
        if (retire_pc !== e_pc) begin
          errors++; $display("[TB] FAIL retire_pc: got %h, expected %h", retire_pc, e_pc);
        end
        checks++;
        if (illegal !== e_ill) begin
          errors++; $display("[TB] FAIL illegal at pc %h: got %b, expected %b", e_pc, illegal, e_ill);
        end
        checks++;
        if (cyc - last != e_lat + waits) begin
          errors++;
          $display("[TB] FAIL latency at pc %h: got %0d, expected %0d", e_pc, cyc - last, e_lat + waits);
        end
        if (e_st) begin
          checks++;
          if (!st_seen || st_addr !== e_sa || st_data !== e_sd) begin
            errors++;
            $display("[TB] FAIL store at pc %h: got seen=%b addr=%h data=%h, expected addr=%h data=%h",
                     e_pc, st_seen, st_addr, st_data, e_sa, e_sd);
          end
        end
        st_seen = 0; waits = 0; last = cyc;
        if (e_hlt) begin
          checks++;
          if (halted !== 1'b1) begin
            errors++; $display("[TB] FAIL halted: got %b, expected 1", halted);
          end
          for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (imem_addr !== m_pc || dmem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) begin
              errors++;
              $display("[TB] FAIL halt_freeze: got pc=%h req=%b retire=%b halted=%b, expected pc=%h 0 0 1",
                       imem_addr, dmem_req, retire, halted, m_pc);
            end
          end
          done = 1;
        end else if (nret >= max_ret) begin
          done = 1;
        end
      end
      if (!done) begin
        dmem_ready = 1'b0;
        if (dmem_req) begin
          req_len++;
          if (wait_left < 0) wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
          if (wait_left == 0) begin
            dmem_ready = 1'b1; wait_left = -1;
            req_log.push_back(req_len); req_len = 0;
            if (dmem_we) begin
              dmem[dmem_addr[11:2]] = dmem_wdata;
              st_seen = 1; st_addr = 32'(dmem_addr); st_data = dmem_wdata;
            end else begin
              dmem_rdata = dmem[dmem_addr[11:2]];
            end
          end else begin
            wait_left--; waits++;
          end
        end
      end
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_addr !== 12'h000 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || retire !== 1'b0 ||
        illegal !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got pc=%h req=%b we=%b ret=%b ill=%b halt=%b, expected 000 0 0 0 0 0",
               imem_addr, dmem_req, dmem_we, retire, illegal, halted);
    end
    checks++;
    if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_counters: got %0d/%0d, expected 0/0", cyc_cnt, ret_cnt);
    end
  endtask

  task automatic test_alu_mem();
    prog = '{enc_i('h08, 0, 1, 5), enc_i('h08, 1, 2, -7), enc_i('h2B, 0, 2, 8),
             enc_i('h23, 0, 3, 8), enc_i('h2B, 0, 3, 12), HALT_W};
    load_prog(); clear_mem(0);
    force_wait = 3;
    run_prog(100, 500);
    force_wait = -1;
    checks++;
    if (ret_log.size() != 6 || ret_log[0] !== 12'h000 || ret_log[1] !== 12'h004) begin
      errors++; $display("[TB] FAIL alu_retire_pcs: got %p, expected first 000 004 of 6", ret_log);
    end
    checks++;
    if (req_log.size() < 1 || req_log[0] != 4) begin
      errors++; $display("[TB] FAIL sw_req_cycles: got %p, expected first 4", req_log);
    end
    checks++;
    if (dmem[2] !== 32'hFFFF_FFFE || dmem[3] !== 32'hFFFF_FFFE) begin
      errors++; $display("[TB] FAIL sw_lw_data: got %h %h, expected fffffffe fffffffe", dmem[2], dmem[3]);
    end
  endtask

  task automatic test_branch();
    prog = '{enc_i('h08, 0, 1, 9), NOP_W, NOP_W, NOP_W, enc_i('h04, 1, 1, -1)};
    load_prog(); clear_mem(0);
    run_prog(7, 300);
    checks++;
    if (ret_log.size() != 7 || ret_log[4] !== 12'h010 || ret_log[6] !== 12'h010 || imem_addr !== 12'h010) begin
      errors++; $display("[TB] FAIL beq_loop: got %p next=%h, expected ... 010 010 010 next=010", ret_log, imem_addr);
    end
    prog = '{enc_i('h08, 0, 1, 9), NOP_W, NOP_W, NOP_W, enc_i('h05, 1, 1, 5),
             enc_i('h05, 1, 0, 1), enc_i('h08, 0, 2, 1), enc_i('h2B, 0, 2, 0), HALT_W};
    load_prog(); clear_mem(1);
    run_prog(100, 500);
    checks++;
    if (ret_log.size() != 8 || ret_log[5] !== 12'h014 || ret_log[6] !== 12'h01C || ret_log[7] !== 12'h020) begin
      errors++; $display("[TB] FAIL bne_paths: got %p, expected 000 004 008 00c 010 014 01c 020", ret_log);
    end
    checks++;
    if (dmem[0] !== 32'd0) begin
      errors++; $display("[TB] FAIL bne_skip: got %h, expected 00000000", dmem[0]);
    end
  endtask

  task automatic test_jump();
    prog = '{enc_j('h40)};
    load_prog(); clear_mem(0);
    imem[64] = enc_i('h08, 0, 1, 7);
    imem[65] = enc_i('h2B, 0, 1, 0);
    imem[66] = HALT_W;
    run_prog(100, 500);
    checks++;
    if (ret_log.size() != 4 || ret_log[1] !== 12'h100 || ret_log[3] !== 12'h108 || dmem[0] !== 32'd7) begin
      errors++; $display("[TB] FAIL jump: got %p mem=%h, expected 000 100 104 108 mem=7", ret_log, dmem[0]);
    end
  endtask

  task automatic test_illegal_halt();
    prog = '{enc_i('h08, 0, 1, 1), enc_i('h2A, 1, 1, 'h1234), enc_r('h3F, 1, 1, 1, 0),
             enc_i('h2B, 0, 1, 0), HALT_W};
    load_prog(); clear_mem(0);
    run_prog(100, 500);
    checks++;
    if (ill_cnt != 2 || dmem[0] !== 32'd1 || dmem[1] !== 32'd0) begin
      errors++; $display("[TB] FAIL illegal_nop: got cnt=%0d mem=%h %h, expected 2 1 0", ill_cnt, dmem[0], dmem[1]);
    end
    checks++;
    if (halted !== 1'b1 || imem_addr !== 12'h014) begin
      errors++; $display("[TB] FAIL halt_pc: got halted=%b pc=%h, expected 1 014", halted, imem_addr);
    end
  endtask

  task automatic test_random(input int n);
    int kind, fns[7];
    fns = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h00, 'h02};
    prog.delete();
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1, 2, 3: prog.push_back(enc_r(fns[$urandom_range(0, 6)], int'($urandom_range(0, 7)),
                                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                         int'($urandom_range(0, 31))));
        4: prog.push_back(enc_i('h08, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom)));
        5: prog.push_back(enc_i('h0A, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom)));
        6: prog.push_back(enc_i($urandom_range(0, 1) ? 'h0C : 'h0D, int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 7)), int'($urandom)));
        7: prog.push_back(enc_i('h2B, 0, int'($urandom_range(0, 7)), int'('h80 + 4 * $urandom_range(0, 15))));
        8: prog.push_back(enc_i('h23, 0, int'($urandom_range(0, 7)), int'('h80 + 4 * $urandom_range(0, 15))));
        default: prog.push_back(enc_i('h3E, 1, 2, 3));
      endcase
    end
    for (int r = 1; r < 8; r++) prog.push_back(enc_i('h2B, 0, r, 'h40 + 4 * r));
    prog.push_back(HALT_W);
    load_prog(); clear_mem(1);
    run_prog(1000, 3000);
    checks++;
    begin
      int bad = 0;
      for (int i = 0; i < 1024; i++) if (dmem[i] !== m_mem[i]) bad++;
      if (bad != 0) begin
        errors++; $display("[TB] FAIL random_mem: got %0d differing words, expected 0", bad);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    int cnt;
    logic [31:0] old;
    prog = '{enc_i('h08, 0, 1, 'h55), enc_i('h2B, 0, 1, 'h20), HALT_W};
    load_prog(); clear_mem(1);
    old = dmem[8];
    rst = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    while (dmem_req !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_mem_reach: got req=%b after %0d cycles, expected 1", dmem_req, cnt);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_addr !== 12'h000 || retire !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_mem_reset: got req=%b we=%b pc=%h ret=%b, expected 0 0 000 0",
               dmem_req, dmem_we, imem_addr, retire);
    end
    checks++;
    if (dmem[8] !== old || cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL mid_mem_state: got mem=%h cnt=%0d/%0d, expected %h 0/0", dmem[8], cyc_cnt, ret_cnt, old);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
`ifdef TAYLOR_PERF_EN
    if (cyc_cnt !== 32'd5 || ret_cnt !== 32'd1 || imem_addr !== 12'h008) begin
      errors++; $display("[TB] FAIL perf_after_reset: got %0d/%0d pc=%h, expected 5/1 008", cyc_cnt, ret_cnt, imem_addr);
    end
`else
    if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0 || imem_addr !== 12'h008) begin
      errors++; $display("[TB] FAIL perf_tied: got %0d/%0d pc=%h, expected 0/0 008", cyc_cnt, ret_cnt, imem_addr);
    end
`endif
  endtask

  initial begin
    $display("[TB] taylor_mc bench start");
    test_reset();
    test_alu_mem();
    test_branch();
    test_jump();
    test_illegal_halt();
    for (int s = 0; s < 3; s++) test_random(24);
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
